// File: rtl/bram_uart_streamer.sv
// bram_uart_streamer: reads a run of BRAM words and streams each one LSB byte first
// through the uart_transmit trigger/busy handshake.
module bram_uart_streamer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int COUNT_WIDTH  = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [ADDR_WIDTH-1:0]  base_addr_in,
  input  logic [COUNT_WIDTH-1:0] word_count_in,
  output logic [ADDR_WIDTH-1:0]  addr_out,
  input  logic [31:0]            data_in,
  input  logic                   uart_busy_in,
  output logic [7:0]             uart_data_out,
  output logic                   uart_trigger_out,
  output logic                   busy_out,
  output logic                   done_out
);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, ACK, DRAIN, NEXT, DONE} state_t;
  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_word;
  logic [1:0]             r_byte_idx;
  logic [7:0]             r_lat;
  logic [31:0]            r_shift;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state          <= IDLE;
      r_count          <= '0;
      r_word           <= '0;
      r_byte_idx       <= '0;
      r_lat            <= '0;
      r_shift          <= '0;
      addr_out         <= '0;
      uart_data_out    <= '0;
      uart_trigger_out <= 1'b0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
    end else begin
      uart_trigger_out <= 1'b0;
      done_out         <= 1'b0;
      case (r_state)
        IDLE: if (start_in) begin
          r_count  <= word_count_in;
          r_word   <= '0;
          r_lat    <= '0;
          busy_out <= 1'b1;
          if (word_count_in != '0) addr_out <= base_addr_in;
          r_state  <= word_count_in == '0 ? DONE : FETCH;
        end
        FETCH: begin
          r_lat <= r_lat + 8'd1;
          if (r_lat == 8'(BRAM_LATENCY - 1)) r_state <= LOAD;
        end
        LOAD: begin
          r_shift    <= data_in;
          r_byte_idx <= '0;
          r_state    <= SEND;
        end
        SEND: if (!uart_busy_in) begin
          uart_data_out    <= r_shift[7:0];
          uart_trigger_out <= 1'b1;
          r_state          <= ACK;
        end
        ACK: if (uart_busy_in) r_state <= DRAIN;
        DRAIN: if (!uart_busy_in) r_state <= NEXT;
        NEXT: if (r_byte_idx != 2'd3) begin
          r_byte_idx <= r_byte_idx + 2'd1;
          r_shift    <= r_shift >> 8;
          r_state    <= SEND;
        end else if (r_word != r_count - 1'b1) begin
          // stepping the address by one wraps modulo 2^ADDR_WIDTH, same as base+word
          r_word   <= r_word + 1'b1;
          addr_out <= addr_out + 1'b1;
          r_lat    <= '0;
          r_state  <= FETCH;
        end else begin
          r_state <= DONE;
        end
        DONE: begin
          done_out <= 1'b1;
          busy_out <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_uart_streamer.sv
// tb_bram_uart_streamer: random and directed transfers checked against a queue-based
// model of the byte stream, with a 2-cycle BRAM and a busy-window transmitter model.
module tb_bram_uart_streamer;
  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] base_addr_in = '0;
  logic [15:0] word_count_in = '0;
  logic [15:0] addr_out;
  logic [31:0] data_in;
  logic [31:0] p1 = '0;
  logic [31:0] p2 = '0;
  logic        uart_busy_in;
  logic        tx_busy = 1'b0;
  logic        uart_trigger_out, busy_out, done_out;
  logic [7:0]  uart_data_out;
  logic [7:0]  last_byte = '0;
  logic [31:0] mem [0:65535];
  logic [7:0]  got_q[$];
  logic [15:0] addr_q[$];
  int          tx_cnt = 0, tx_len = 0;
  int          total = 0, bad = 0;
  int          n_trig = 0, n_done = 0, n_viol = 0, n_unstable = 0;
  bit          seen = 0, pbusy = 0;
  logic [15:0] paddr = '0;
  int          t;

  always #5 clk_in = ~clk_in;

  bram_uart_streamer dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .word_count_in(word_count_in),
    .addr_out(addr_out), .data_in(data_in), .uart_busy_in(uart_busy_in),
    .uart_data_out(uart_data_out), .uart_trigger_out(uart_trigger_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  assign data_in      = p2;
  assign uart_busy_in = tx_busy | stall;

  always @(posedge clk_in) begin
    p1 <= mem[addr_out];
    p2 <= p1;
  end

  // transmitter: busy for tx_len cycles (random when 0) after each trigger
  always @(posedge clk_in) begin
    if (uart_trigger_out) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_len != 0 ? tx_len : int'($urandom_range(2, 12));
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else begin
      tx_busy <= 1'b0;
      tx_cnt  <= 0;
    end
  end

  always @(negedge clk_in) begin
    if (rst_in) seen = 0;
    if (uart_trigger_out) begin
      n_trig++;
      got_q.push_back(uart_data_out);
      if (uart_busy_in) n_viol++;
      last_byte = uart_data_out;
      seen = 1;
    end else if (seen && uart_data_out != last_byte) begin
      n_unstable++;
    end
    if (done_out) n_done++;
    if (busy_out && (!pbusy || addr_out != paddr)) addr_q.push_back(addr_out);
    pbusy = busy_out;
    paddr = addr_out;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [15:0] c);
    @(negedge clk_in);
    start_in      = 1'b1;
    base_addr_in  = b;
    word_count_in = c;
    @(negedge clk_in);
    start_in = 1'b0;
  endtask

  task automatic run_xfer(input logic [15:0] b, input logic [15:0] c, input int stall_cyc);
    logic [7:0]  eb[$];
    logic [15:0] ea[$];
    int          tw;
    got_q.delete();
    addr_q.delete();
    n_trig = 0;
    n_done = 0;
    for (int w = 0; w < int'(c); w++) begin
      logic [15:0] a;
      a = b + 16'(w);
      ea.push_back(a);
      for (int k = 0; k < 4; k++) eb.push_back(8'(mem[a] >> (8 * k)));
    end
    stall = stall_cyc > 0;
    pulse_start(b, c);
    if (stall_cyc > 0) begin
      repeat (stall_cyc) @(negedge clk_in);
      chk("stall_no_trigger", n_trig, 0);
      stall = 1'b0;
    end
    tw = 0;
    while (!done_out && tw < 5000) begin
      @(negedge clk_in);
      tw++;
    end
    chk("done_seen", {31'd0, done_out}, 1);
    chk("busy_at_done", {31'd0, busy_out}, 0);
    if (c == 0) chk("zero_count_latency", {31'd0, tw <= 2}, 1);
    repeat (3) @(negedge clk_in);
    chk("done_pulses", n_done, 1);
    chk("triggers", n_trig, 4 * int'(c));
    chk("byte_count", got_q.size(), eb.size());
    for (int i = 0; i < eb.size() && i < got_q.size(); i++) chk("byte", {24'd0, got_q[i]}, {24'd0, eb[i]});
    if (c != 0) begin
      chk("addr_count", addr_q.size(), ea.size());
      for (int i = 0; i < ea.size() && i < addr_q.size(); i++) chk("addr", {16'd0, addr_q[i]}, {16'd0, ea[i]});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_addr", {16'd0, addr_out}, 0);
    chk("rst_data", {24'd0, uart_data_out}, 0);
    chk("rst_trigger", {31'd0, uart_trigger_out}, 0);
    chk("rst_busy", {31'd0, busy_out}, 0);
    chk("rst_done", {31'd0, done_out}, 0);
    rst_in = 1'b0;

    mem[5] = 32'hDDCCBBAA;
    tx_len = 10;
    run_xfer(16'd5, 16'd1, 0);

    mem[0] = 32'h03020100;
    mem[1] = 32'h07060504;
    mem[2] = 32'h0B0A0908;
    tx_len = 0;
    run_xfer(16'd0, 16'd3, 0);

    run_xfer(16'h1234, 16'd0, 0);

    mem[16'h200] = $urandom;
    mem[16'h201] = $urandom;
    run_xfer(16'h200, 16'd2, 50);

    mem[16'hFFFF] = $urandom;
    mem[16'h0000] = $urandom;
    mem[16'h0010] = $urandom;
    fork
      run_xfer(16'hFFFF, 16'd2, 0);
      begin
        repeat (30) @(negedge clk_in);
        pulse_start(16'h0010, 16'd5);
      end
    join

    for (int w = 0; w < 3; w++) mem[16'h300 + 16'(w)] = $urandom;
    tx_len = 6;
    n_trig = 0;
    pulse_start(16'h300, 16'd3);
    t = 0;
    while (n_trig < 2 && t < 2000) begin
      @(posedge clk_in);
      t++;
    end
    chk("two_triggers_before_reset", n_trig, 2);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_addr", {16'd0, addr_out}, 0);
    chk("midrst_data", {24'd0, uart_data_out}, 0);
    chk("midrst_trigger", {31'd0, uart_trigger_out}, 0);
    chk("midrst_busy", {31'd0, busy_out}, 0);
    chk("midrst_done", {31'd0, done_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (40) @(negedge clk_in);
    chk("no_trigger_after_reset", n_trig, 2);
    chk("idle_after_reset", {31'd0, busy_out}, 0);
    tx_len = 0;
    run_xfer(16'h300, 16'd3, 0);

    n_trig = 0;
    @(negedge clk_in);
    rst_in        = 1'b1;
    start_in      = 1'b1;
    base_addr_in  = 16'h400;
    word_count_in = 16'd1;
    @(negedge clk_in);
    start_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (5) @(negedge clk_in);
    chk("reset_beats_start_busy", {31'd0, busy_out}, 0);
    chk("reset_beats_start_trig", n_trig, 0);

    for (int r = 0; r < 6; r++) begin
      logic [15:0] b, c;
      b = 16'($urandom);
      c = 16'($urandom_range(1, 4));
      for (int w = 0; w < int'(c); w++) mem[b + 16'(w)] = $urandom;
      run_xfer(b, c, 0);
    end

    chk("trigger_while_busy", n_viol, 0);
    chk("data_stable", n_unstable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
